// File: rtl/async_pipe_arbiter.sv
// async_pipe_arbiter: clocked front end for a two-phase bundled-data
// micropipeline. Two synchronous sources share the pipeline input through
// round-robin arbitration. The winning token is registered onto pipe_data,
// held for a programmable bundling delay, then announced by toggling
// pipe_req. New traffic waits until the pipeline's acknowledge transition
// has been synchronised back into the clock domain.
//
// Source handshake: a token moves from source N into the block on a rising
// edge where srcN_valid and srcN_ready are both high. srcN_ready is a
// combinational grant that can only be high in IDLE (and never in reset),
// and at most one source is granted per cycle. A source must hold valid and
// data stable until it sees ready.
module async_pipe_arbiter #(
    parameter int WIDTH        = 8,
    parameter int SETUP_CYCLES = 1,   // 1..15, the setup counter is 4 bits
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             src0_valid,
    input  logic [WIDTH-1:0] src0_data,
    output logic             src0_ready,
    input  logic             src1_valid,
    input  logic [WIDTH-1:0] src1_data,
    output logic             src1_ready,
    output logic [WIDTH-1:0] pipe_data,
    output logic             pipe_req,
    input  logic             pipe_ack,
    output logic             busy,
    output logic             last_src,
    output logic [CNT_W-1:0] tok_cnt
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SETUP    = 2'd1,
        WAIT_ACK = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic               req_q, req_d;
    logic               last_src_q, last_src_d;
    logic [CNT_W-1:0]   tok_cnt_q, tok_cnt_d;
    logic               ack_meta_q, ack_meta_d;
    logic               ack_s_q, ack_s_d;

    logic               hs_done;
    logic               can_accept;
    logic               pick1;

    // Handshake is complete when the synchronised ack has caught up with req.
    assign hs_done = (ack_s_q == req_q);

    // State register: FSM, datapath and the two-flop ack synchroniser.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            data_q     <= '0;
            req_q      <= 1'b0;
            last_src_q <= 1'b1;
            tok_cnt_q  <= '0;
            ack_meta_q <= 1'b0;
            ack_s_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            req_q      <= req_d;
            last_src_q <= last_src_d;
            tok_cnt_q  <= tok_cnt_d;
            ack_meta_q <= ack_meta_d;
            ack_s_q    <= ack_s_d;
        end
    end

    // Next-state: accept in IDLE, count down the bundling delay in SETUP,
    // then wait for the ack to match req before returning to IDLE.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        req_d      = req_q;
        last_src_d = last_src_q;
        tok_cnt_d  = tok_cnt_q;
        ack_meta_d = pipe_ack;
        ack_s_d    = ack_meta_q;
        case (state_q)
            IDLE: begin
                if (src0_ready || src1_ready) begin
                    data_d     = pick1 ? src1_data : src0_data;
                    last_src_d = pick1;
                    cnt_d      = 4'(SETUP_CYCLES);
                    state_d    = SETUP;
                end
            end
            SETUP: begin
                // Counter hits zero SETUP_CYCLES edges after accept; the
                // toggle happens on the edge after that.
                if (cnt_q == 4'd0) begin
                    req_d   = ~req_q;
                    state_d = WAIT_ACK;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            WAIT_ACK: begin
                if (hs_done) begin
                    tok_cnt_d = tok_cnt_q + CNT_W'(1);
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: round-robin grant (ties go to the source not served last)
    // and the busy flag. Grants are blocked in reset and while an ack
    // transition is still outstanding, which also absorbs a pipeline that
    // leaves reset with its acknowledge high.
    always_comb begin
        can_accept = !rst && (state_q == IDLE) && hs_done;
        pick1      = src1_valid && (!src0_valid || !last_src_q);
        src0_ready = can_accept && src0_valid && !pick1;
        src1_ready = can_accept && pick1;
        busy       = (state_q != IDLE);
    end

    assign pipe_data = data_q;
    assign pipe_req  = req_q;
    assign last_src  = last_src_q;
    assign tok_cnt   = tok_cnt_q;

endmodule

// File: tb/tb_async_pipe_arbiter.sv
// Bench for async_pipe_arbiter: directed token lists per source, expected
// grants pushed to a queue, and a negedge monitor that checks each accept,
// the data hold, each req toggle and each completion against that queue.
module tb_async_pipe_arbiter;

    localparam int WIDTH = 8;
    localparam int S     = 4;
    localparam int CW    = 4;
    localparam int W     = WIDTH + 1;   // {src, data}

    logic             clk = 1'b0;
    logic             rst;
    logic             src0_valid, src1_valid;
    logic [WIDTH-1:0] src0_data, src1_data;
    logic             src0_ready, src1_ready;
    logic [WIDTH-1:0] pipe_data;
    logic             pipe_req;
    logic             pipe_ack;
    logic             busy;
    logic             last_src;
    logic [CW-1:0]    tok_cnt;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [W-1:0]     exp_q[$];
    logic [WIDTH-1:0] src0_list[$];
    logic [WIDTH-1:0] src1_list[$];

    // ack model controls
    logic ack_en    = 1'b1;
    logic ack_force = 1'b0;
    int   ack_dly   = 3;

    logic wrap_seen = 1'b0;

    async_pipe_arbiter #(.WIDTH(WIDTH), .SETUP_CYCLES(S), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .src0_valid(src0_valid), .src0_data(src0_data), .src0_ready(src0_ready),
        .src1_valid(src1_valid), .src1_data(src1_data), .src1_ready(src1_ready),
        .pipe_data(pipe_data), .pipe_req(pipe_req), .pipe_ack(pipe_ack),
        .busy(busy), .last_src(last_src), .tok_cnt(tok_cnt)
    );

    // clock and cycle counter
    always #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish, required finish before 400000");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Pipeline ack model: mirrors req back after ack_dly cycles; follows the
    // pipeline's reset; ack_force pins it high.
    initial begin
        int ack_wait;
        ack_wait = 0;
        pipe_ack = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (ack_force) begin
                pipe_ack = 1'b1;
                ack_wait = 0;
            end else if (rst) begin
                pipe_ack = 1'b0;
                ack_wait = 0;
            end else if (ack_en && (pipe_ack != pipe_req)) begin
                ack_wait++;
                if (ack_wait >= ack_dly) begin
                    pipe_ack = pipe_req;
                    ack_wait = 0;
                end
            end else begin
                ack_wait = 0;
            end
        end
    end

    // Monitor / scoreboard
    initial begin
        logic         prev_req, prev_busy, have_cur, a0, a1;
        logic [W-1:0] cur, e;
        logic [CW-1:0] exp_tok;
        int           acc_cyc;
        prev_req = 0; prev_busy = 0; have_cur = 0; exp_tok = '0; acc_cyc = 0;
        cur = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_req  = 1'b0;
                prev_busy = 1'b0;
                have_cur  = 1'b0;
                exp_tok   = '0;
            end else begin
                chk("ready_overlap", {31'd0, src0_ready & src1_ready}, 32'd0);
                chk("ready_while_busy", {31'd0, busy & (src0_ready | src1_ready)}, 32'd0);
                if (have_cur && busy)
                    chk("data_hold", {24'd0, pipe_data}, {24'd0, cur[WIDTH-1:0]});
                a0 = src0_valid && src0_ready;
                a1 = src1_valid && src1_ready;
                if (a0 || a1) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_accept", 32'd1, 32'd0);
                    end else begin
                        cur = exp_q[0];
                        have_cur = 1'b1;
                        acc_cyc = cyc + 1;
                        chk("grant_src", {31'd0, a1}, {31'd0, cur[WIDTH]});
                        chk("grant_data", {24'd0, a1 ? src1_data : src0_data},
                            {24'd0, cur[WIDTH-1:0]});
                    end
                end
                if (pipe_req != prev_req) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_req", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("req_data", {24'd0, pipe_data}, {24'd0, e[WIDTH-1:0]});
                        chk("req_last_src", {31'd0, last_src}, {31'd0, e[WIDTH]});
                        chk("req_latency", cyc - acc_cyc, S + 1);
                    end
                end
                prev_req = pipe_req;
                if (prev_busy && !busy) begin
                    exp_tok = exp_tok + 1'b1;
                    if (exp_tok == '0) wrap_seen = 1'b1;
                    chk("tok_cnt", {28'd0, tok_cnt}, {28'd0, exp_tok});
                    have_cur = 1'b0;
                end
                prev_busy = busy;
            end
        end
    end

    // Driver tasks
    task automatic load_srcs();
        src0_valid = (src0_list.size() != 0);
        src0_data  = (src0_list.size() != 0) ? src0_list[0] : '0;
        src1_valid = (src1_list.size() != 0);
        src1_data  = (src1_list.size() != 0) ? src1_list[0] : '0;
    endtask

    task automatic push_exp(input logic src, input logic [WIDTH-1:0] d);
        exp_q.push_back({src, d});
    endtask

    task automatic feed(input int budget);
        int  n;
        logic a0, a1;
        n = 0;
        load_srcs();
        while ((src0_list.size() != 0 || src1_list.size() != 0 ||
                exp_q.size() != 0 || busy) && n < budget) begin
            @(negedge clk);
            a0 = src0_valid && src0_ready;
            a1 = src1_valid && src1_ready;
            @(posedge clk);
            #1;
            if (a0) void'(src0_list.pop_front());
            if (a1) void'(src1_list.pop_front());
            load_srcs();
            n++;
        end
        if (n >= budget) begin
            chk("feed_timeout", 32'd1, 32'd0);
            src0_list.delete();
            src1_list.delete();
            exp_q.delete();
            load_srcs();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Main stimulus
    initial begin
        int n, first;
        rst = 1'b1;
        src0_valid = 0; src1_valid = 0; src0_data = '0; src1_data = '0;
        do_reset();

        // reset values
        chk("rst_pipe_req",  {31'd0, pipe_req}, 32'd0);
        chk("rst_pipe_data", {24'd0, pipe_data}, 32'd0);
        chk("rst_busy",      {31'd0, busy}, 32'd0);
        chk("rst_last_src",  {31'd0, last_src}, 32'd1);
        chk("rst_tok_cnt",   {28'd0, tok_cnt}, 32'd0);
        chk("rst_readies",   {30'd0, src0_ready, src1_ready}, 32'd0);

        // single token from source 0, ack after 3 cycles
        src0_list = '{8'hA5};
        push_exp(1'b0, 8'hA5);
        feed(100);
        chk("t1_tok_cnt", {28'd0, tok_cnt}, 32'd1);
        chk("t1_pipe_req", {31'd0, pipe_req}, 32'd1);
        chk("t1_pipe_data", {24'd0, pipe_data}, 32'h0000_00A5);

        // both sources valid: strict alternation starting with source 0
        do_reset();
        src0_list = '{8'h10, 8'h11, 8'h12};
        src1_list = '{8'h20, 8'h21, 8'h22};
        push_exp(1'b0, 8'h10); push_exp(1'b1, 8'h20);
        push_exp(1'b0, 8'h11); push_exp(1'b1, 8'h21);
        push_exp(1'b0, 8'h12); push_exp(1'b1, 8'h22);
        feed(300);
        chk("alt_last_src", {31'd0, last_src}, 32'd1);
        chk("alt_tok_cnt", {28'd0, tok_cnt}, 32'd6);

        // only source 1 valid: it wins even though it was served last
        src1_list = '{8'h5A, 8'h5B};
        push_exp(1'b1, 8'h5A); push_exp(1'b1, 8'h5B);
        feed(100);
        chk("s1_last_src", {31'd0, last_src}, 32'd1);
        chk("s1_tok_cnt", {28'd0, tok_cnt}, 32'd8);

        // reset while waiting for ack
        ack_en = 1'b0;
        src0_list = '{8'h99};
        push_exp(1'b0, 8'h99);
        load_srcs();
        n = 0;
        while (n < 10) begin
            @(negedge clk);
            if (src0_ready) break;
            n++;
        end
        chk("mr_accept_timeout", {31'd0, n >= 10}, 32'd0);
        @(posedge clk);
        #1;
        void'(src0_list.pop_front());
        load_srcs();
        n = 0;
        while (exp_q.size() != 0 && n < 30) begin
            @(posedge clk);
            n++;
        end
        chk("mr_toggle_timeout", {31'd0, n >= 30}, 32'd0);
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("mr_pipe_req",  {31'd0, pipe_req}, 32'd0);
        chk("mr_pipe_data", {24'd0, pipe_data}, 32'd0);
        chk("mr_busy",      {31'd0, busy}, 32'd0);
        chk("mr_last_src",  {31'd0, last_src}, 32'd1);
        chk("mr_tok_cnt",   {28'd0, tok_cnt}, 32'd0);
        chk("mr_readies",   {30'd0, src0_ready, src1_ready}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        ack_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // 16 tokens, fast ack: tok_cnt wraps 15 -> 0
        ack_dly = 1;
        for (int i = 0; i < 8; i++) begin
            src0_list.push_back(8'h30 + 8'(i));
            src1_list.push_back(8'h40 + 8'(i));
            push_exp(1'b0, 8'h30 + 8'(i));
            push_exp(1'b1, 8'h40 + 8'(i));
        end
        feed(800);
        chk("wrap_tok_cnt", {28'd0, tok_cnt}, 32'd0);
        chk("wrap_seen", {31'd0, wrap_seen}, 32'd1);

        // pipeline leaves reset with ack high: nothing granted until it drops
        ack_force = 1'b1;
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("fa_ready_in_rst", {30'd0, src0_ready, src1_ready}, 32'd0);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        src0_list = '{8'h77};
        push_exp(1'b0, 8'h77);
        load_srcs();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("fa_ready_ack_high", {30'd0, src0_ready, src1_ready}, 32'd0);
        end
        @(posedge clk);
        #1 ack_force = 1'b0;
        n = 0;
        while (n < 10) begin
            @(negedge clk);
            if (pipe_ack == 1'b0) break;
            n++;
        end
        chk("fa_ack_drop_timeout", {31'd0, n >= 10}, 32'd0);
        first = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (src0_ready) begin
                first = k;
                break;
            end
        end
        chk("fa_resume_latency", first, 32'd2);
        if (first != 0) begin
            @(posedge clk);
            #1;
            void'(src0_list.pop_front());
        end
        feed(100);
        chk("fa_tok_cnt", {28'd0, tok_cnt}, 32'd1);

        chk("exp_q_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
